// File: rtl/led7seg_scan_drv.sv
// Multiplexed N-digit 7-segment scan driver with blanking gap, blink, zero suppression
// and frame-synchronous latching so a displayed frame never mixes two latched values.
module led7seg_scan_drv #(
  parameter int C_DIGITS = 4,
  parameter int C_FCK    = 48_000_000,
  parameter int C_FSCAN  = 1_000,
  parameter int C_FBLINK = 2,
  parameter int C_GAP    = 16
) (
  input  logic                  CK_i,
  input  logic                  RST_i,
  input  logic                  EN_CK_i,
  input  logic                  LATCH_i,
  input  logic [4*C_DIGITS-1:0] DAT_i,
  input  logic [C_DIGITS-1:0]   DOT_i,
  input  logic [C_DIGITS-1:0]   BLINK_i,
  input  logic                  ZSUP_i,
  output logic [C_DIGITS-1:0]   ACT_DIGIT_o,
  output logic [6:0]            SEG7_o,
  output logic                  DP_o,
  output logic                  FRAME_o
);

  localparam int C_SLOT = C_FCK / (C_FSCAN * C_DIGITS);
  localparam int C_HALF = C_FCK / (2 * C_FBLINK);
  localparam int PW     = (C_SLOT > 1) ? $clog2(C_SLOT) : 1;
  localparam int BW     = (C_HALF > 1) ? $clog2(C_HALF) : 1;
  localparam int IW     = (C_DIGITS > 1) ? $clog2(C_DIGITS) : 1;
  localparam logic [PW-1:0] SLOT_LAST = PW'(C_SLOT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(C_HALF - 1);
  localparam logic [PW-1:0] GAP_END   = PW'(C_GAP);
  localparam logic [IW-1:0] IDX_LAST  = IW'(C_DIGITS - 1);

  logic [PW-1:0]         prescCnt_q, prescCnt_d;
  logic [IW-1:0]         digitIdx_q, digitIdx_d;
  logic [BW-1:0]         blinkCnt_q, blinkCnt_d;
  logic                  blinkPhase_q, blinkPhase_d;
  logic [4*C_DIGITS-1:0] pendDat_q, pendDat_d, actDat_q, actDat_d;
  logic [C_DIGITS-1:0]   pendDot_q, pendDot_d, actDot_q, actDot_d;
  logic [C_DIGITS-1:0]   pendBlink_q, pendBlink_d, actBlink_q, actBlink_d;
  logic                  pendZsup_q, pendZsup_d, actZsup_q, actZsup_d;
  logic [C_DIGITS-1:0]   actDigit_q, actDigit_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d, frame_q, frame_d;

  logic                  frameStart;
  logic [3:0]            digitVal;
  logic                  digitDot, digitBlink, digitSupp;

  function automatic logic [6:0] hexSeg(input logic [3:0] v);
    case (v)
      4'h0: hexSeg = 7'h3F;  4'h1: hexSeg = 7'h06;  4'h2: hexSeg = 7'h5B;  4'h3: hexSeg = 7'h4F;
      4'h4: hexSeg = 7'h66;  4'h5: hexSeg = 7'h6D;  4'h6: hexSeg = 7'h7D;  4'h7: hexSeg = 7'h07;
      4'h8: hexSeg = 7'h7F;  4'h9: hexSeg = 7'h6F;  4'hA: hexSeg = 7'h77;  4'hB: hexSeg = 7'h7C;
      4'hC: hexSeg = 7'h39;  4'hD: hexSeg = 7'h5E;  4'hE: hexSeg = 7'h79;  default: hexSeg = 7'h71;
    endcase
  endfunction

  // Pick the attributes of the digit currently being scanned out of the active set.
  always_comb begin
    digitVal   = '0;
    digitDot   = 1'b0;
    digitBlink = 1'b0;
    for (int k = 0; k < C_DIGITS; k++) begin
      if (digitIdx_q == IW'(k)) begin
        digitVal   = actDat_q[4*k +: 4];
        digitDot   = actDot_q[k];
        digitBlink = actBlink_q[k];
      end
    end
    digitSupp  = actZsup_q && (digitIdx_q != '0) && ((actDat_q >> {digitIdx_q, 2'b00}) == '0);
    frameStart = (prescCnt_q == '0) && (digitIdx_q == '0);
  end

  always_comb begin
    prescCnt_d   = prescCnt_q;
    digitIdx_d   = digitIdx_q;
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    pendDat_d    = pendDat_q;
    pendDot_d    = pendDot_q;
    pendBlink_d  = pendBlink_q;
    pendZsup_d   = pendZsup_q;
    actDat_d     = actDat_q;
    actDot_d     = actDot_q;
    actBlink_d   = actBlink_q;
    actZsup_d    = actZsup_q;
    actDigit_d   = actDigit_q;
    seg_d        = seg_q;
    dp_d         = dp_q;
    frame_d      = frame_q;
    if (EN_CK_i) begin
      if (prescCnt_q == SLOT_LAST) begin
        prescCnt_d = '0;
        digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + 1'b1;
      end else begin
        prescCnt_d = prescCnt_q + 1'b1;
      end
      if (blinkCnt_q == HALF_LAST) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
      if (LATCH_i) begin
        pendDat_d   = DAT_i;
        pendDot_d   = DOT_i;
        pendBlink_d = BLINK_i;
        pendZsup_d  = ZSUP_i;
      end
      // Active set only changes at the frame boundary; a latch on this same cycle waits a frame.
      if (frameStart) begin
        actDat_d   = pendDat_q;
        actDot_d   = pendDot_q;
        actBlink_d = pendBlink_q;
        actZsup_d  = pendZsup_q;
      end
      frame_d = frameStart;
      if (prescCnt_q < GAP_END) begin
        actDigit_d = '0;
        seg_d      = '0;
        dp_d       = 1'b0;
      end else begin
        actDigit_d = C_DIGITS'(1) << digitIdx_q;
        seg_d      = (digitSupp || (blinkPhase_q && digitBlink)) ? 7'h00 : hexSeg(digitVal);
        dp_d       = digitDot && !(blinkPhase_q && digitBlink);
      end
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      prescCnt_q   <= '0;
      digitIdx_q   <= '0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      pendDat_q    <= '0;
      pendDot_q    <= '0;
      pendBlink_q  <= '0;
      pendZsup_q   <= 1'b0;
      actDat_q     <= '0;
      actDot_q     <= '0;
      actBlink_q   <= '0;
      actZsup_q    <= 1'b0;
      actDigit_q   <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      prescCnt_q   <= prescCnt_d;
      digitIdx_q   <= digitIdx_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      pendDat_q    <= pendDat_d;
      pendDot_q    <= pendDot_d;
      pendBlink_q  <= pendBlink_d;
      pendZsup_q   <= pendZsup_d;
      actDat_q     <= actDat_d;
      actDot_q     <= actDot_d;
      actBlink_q   <= actBlink_d;
      actZsup_q    <= actZsup_d;
      actDigit_q   <= actDigit_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_q      <= frame_d;
    end
  end

  assign ACT_DIGIT_o = actDigit_q;
  assign SEG7_o      = seg_q;
  assign DP_o        = dp_q;
  assign FRAME_o     = frame_q;

endmodule

// File: tb/tb_led7seg_scan_drv.sv
// Randomized bench for led7seg_scan_drv: every cycle is compared against a count-based
// model that derives slot, digit and blink phase from the number of enabled cycles since reset.
module tb_led7seg_scan_drv;
  localparam int D      = 4;
  localparam int FCK    = 1000;
  localparam int FSCAN  = 10;
  localparam int FBLINK = 5;
  localparam int GAP    = 2;
  localparam int SLOT   = FCK / (FSCAN * D);
  localparam int HALF   = FCK / (2 * FBLINK);

  logic        clock = 1'b0;
  logic        sRst = 1'b1, sEn = 1'b0, sLatch = 1'b0, sZsup = 1'b0;
  logic [15:0] sDat = '0;
  logic [3:0]  sDot = '0, sBlink = '0;
  logic [3:0]  actDigit;
  logic [6:0]  seg;
  logic        dp, frame;

  always #5 clock = ~clock;

  led7seg_scan_drv #(
    .C_DIGITS(D), .C_FCK(FCK), .C_FSCAN(FSCAN), .C_FBLINK(FBLINK), .C_GAP(GAP)
  ) dut (
    .CK_i(clock), .RST_i(sRst), .EN_CK_i(sEn), .LATCH_i(sLatch),
    .DAT_i(sDat), .DOT_i(sDot), .BLINK_i(sBlink), .ZSUP_i(sZsup),
    .ACT_DIGIT_o(actDigit), .SEG7_o(seg), .DP_o(dp), .FRAME_o(frame)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Reference model state: n counts enabled cycles since the last reset
  int          n = 0;
  logic [15:0] pDat = '0, aDat = '0;
  logic [3:0]  pDot = '0, aDot = '0, pBlink = '0, aBlink = '0;
  logic        pZsup = 1'b0, aZsup = 1'b0;
  logic [3:0]  eAct = '0;
  logic [6:0]  eSeg = '0;
  logic        eDp = 1'b0, eFrame = 1'b0;
  logic [6:0]  hexTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic modelStep();
    int  presc, idx, nib;
    bit  supp, dark;
    if (sRst) begin
      n = 0;
      pDat = '0; pDot = '0; pBlink = '0; pZsup = 1'b0;
      aDat = '0; aDot = '0; aBlink = '0; aZsup = 1'b0;
      eAct = '0; eSeg = '0; eDp = 1'b0; eFrame = 1'b0;
    end else if (sEn) begin
      presc  = n % SLOT;
      idx    = (n / SLOT) % D;
      nib    = (int'(aDat) / (1 << (4 * idx))) % 16;
      supp   = aZsup && (idx > 0) && ((int'(aDat) / (1 << (4 * idx))) == 0);
      dark   = (((n / HALF) % 2) == 1) && aBlink[idx];
      eFrame = (n % (SLOT * D)) == 0;
      if (presc < GAP) begin
        eAct = '0; eSeg = '0; eDp = 1'b0;
      end else begin
        eAct = 4'(1 << idx);
        eSeg = (supp || dark) ? 7'h00 : hexTab[nib];
        eDp  = aDot[idx] && !dark;
      end
      if (eFrame) begin
        aDat = pDat; aDot = pDot; aBlink = pBlink; aZsup = pZsup;
      end
      if (sLatch) begin
        pDat = sDat; pDot = sDot; pBlink = sBlink; pZsup = sZsup;
      end
      n++;
    end
  endtask

  // One clock with the current stimulus, then compare all outputs against the model
  task automatic applyStimulus();
    modelStep();
    @(posedge clock);
    #1;
    cycle++;
    checkOutput("act",   32'(actDigit), 32'(eAct));
    checkOutput("seg",   32'(seg),      32'(eSeg));
    checkOutput("dp",    32'(dp),       32'(eDp));
    checkOutput("frame", 32'(frame),    32'(eFrame));
  endtask

  task automatic runCycles(input int cnt);
    for (int i = 0; i < cnt; i++) applyStimulus();
  endtask

  task automatic latchOnce(input logic [15:0] dat, input logic [3:0] dot,
                           input logic [3:0] blink, input logic zsup);
    sDat = dat; sDot = dot; sBlink = blink; sZsup = zsup; sLatch = 1'b1;
    applyStimulus();
    sLatch = 1'b0;
  endtask

  task automatic runUntilSlot(input int idx, input int presc);
    int guard = 0;
    while ((((n / SLOT) % D) != idx || (n % SLOT) != presc) && guard < 1000) begin
      applyStimulus();
      guard++;
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    sRst = 1'b1; sEn = 1'b1;
    runCycles(3);
    sRst = 1'b0;

    latchOnce(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    runCycles(2 * SLOT * D);

    latchOnce(16'h0050, 4'b0000, 4'b0000, 1'b1);
    runCycles(2 * SLOT * D);
    latchOnce(16'h0000, 4'b0000, 4'b0000, 1'b1);
    runCycles(2 * SLOT * D);

    latchOnce(16'h8765, 4'b0100, 4'b0100, 1'b0);
    runCycles(5 * HALF);

    runUntilSlot(2, 5);
    latchOnce(16'h1111, 4'b0011, 4'b0000, 1'b0);
    runCycles(10);
    latchOnce(16'h2222, 4'b1000, 4'b0000, 1'b0);
    runCycles(2 * SLOT * D);

    runUntilSlot(1, 10);
    sEn = 1'b0;
    runCycles(40);
    sEn = 1'b1;
    runCycles(SLOT * D);

    runUntilSlot(3, 12);
    sRst = 1'b1;
    runCycles(2);
    sRst = 1'b0;
    latchOnce(16'h4C3B, 4'b1010, 4'b0000, 1'b0);
    runCycles(2 * SLOT * D);

    for (int i = 0; i < 1500; i++) begin
      sEn    = ($urandom_range(0, 9) != 0);
      sLatch = ($urandom_range(0, 29) == 0);
      sRst   = ($urandom_range(0, 499) == 0);
      sDat   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      sDot   = 4'($urandom);
      sBlink = 4'($urandom);
      sZsup  = 1'($urandom);
      applyStimulus();
    end
    sRst = 1'b0; sLatch = 1'b0; sEn = 1'b1;
    runCycles(SLOT * D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
